stopwatch_ctrl: RTL and testbench

- Mode and sequencing controller for the stopwatch; consumes the single-cycle tick pulses from the clock divider (1 Hz, 2 Hz, 400 Hz, 4 Hz).
- Runs the MM:SS BCD time counters and handles pause and manual adjust.
- Schedules the 4-digit seven-segment multiplex scan, including blinking of the field under adjustment.
- Sits between the clock divider and the segment decoder.

---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - tick/control inputs and display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_scan;
    logic       tick_blink;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] an;
    logic [3:0] digit;
    logic       blank;
    logic       running;

    modport master (
        output tick_1hz, tick_2hz, tick_scan, tick_blink, pause_btn, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, an, digit, blank, running
    );

    modport slave (
        input  tick_1hz, tick_2hz, tick_scan, tick_blink, pause_btn, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, an, digit, blank, running
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM, MM:SS BCD counters and 4-digit scan with adjust blink
module stopwatch_ctrl #(
    parameter int MIN_MAX       = 59,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PAUSED = 2'd1,
        S_ADJUST = 2'd2
    } state_t;

    localparam state_t     RESET_STATE = START_RUNNING ? S_RUN : S_PAUSED;
    localparam logic [3:0] MAX_T       = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_O       = 4'(MIN_MAX % 10);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [1:0] scan_idx_q, scan_idx_d;
    logic       blink_q, blink_d;
    logic [3:0] an_q, an_d;
    logic [3:0] digit_q, digit_d;
    logic       blank_q, blank_d;
    logic       running_q, running_d;

    logic [8:0] sec_nxt;
    logic [7:0] min_nxt;
    logic [3:0] slot_an;
    logic [3:0] slot_digit;
    logic       slot_selected;

    // Returns {carry, tens, ones}; carry marks the 59 -> 00 rollover.
    function automatic logic [8:0] sec_inc(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd9) begin
            if (t == 4'd5) sec_inc = 9'b1_0000_0000;
            else           sec_inc = {1'b0, t + 4'd1, 4'd0};
        end else begin
            sec_inc = {1'b0, t, o + 4'd1};
        end
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] o);
        if (t == MAX_T && o == MAX_O) min_inc = 8'h00;
        else if (o == 4'd9)           min_inc = {t + 4'd1, 4'd0};
        else                          min_inc = {t, o + 4'd1};
    endfunction

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        sec_nxt    = sec_inc(sec_tens_q, sec_ones_q);
        min_nxt    = min_inc(min_tens_q, min_ones_q);

        case (state_q)
            S_RUN: begin
                // Entering adjust takes priority and drops a coincident 1 Hz tick.
                if (sw.adj) begin
                    state_d = S_ADJUST;
                    saved_d = S_RUN;
                end else begin
                    if (sw.tick_1hz) begin
                        {sec_tens_d, sec_ones_d} = sec_nxt[7:0];
                        if (sec_nxt[8]) {min_tens_d, min_ones_d} = min_nxt;
                    end
                    if (sw.pause_btn) state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (sw.adj) begin
                    state_d = S_ADJUST;
                    saved_d = S_PAUSED;
                end else if (sw.pause_btn) begin
                    state_d = S_RUN;
                end
            end
            S_ADJUST: begin
                if (!sw.adj) begin
                    state_d = saved_q;
                end else if (sw.tick_2hz) begin
                    if (sw.sel) {sec_tens_d, sec_ones_d} = sec_nxt[7:0];
                    else        {min_tens_d, min_ones_d} = min_nxt;
                end
            end
            default: state_d = RESET_STATE;
        endcase

        scan_idx_d = scan_idx_q + {1'b0, sw.tick_scan};
        blink_d    = blink_q ^ sw.tick_blink;

        case (scan_idx_q)
            2'd0:    begin slot_an = 4'b1110; slot_digit = sec_ones_q; end
            2'd1:    begin slot_an = 4'b1101; slot_digit = sec_tens_q; end
            2'd2:    begin slot_an = 4'b1011; slot_digit = min_ones_q; end
            default: begin slot_an = 4'b0111; slot_digit = min_tens_q; end
        endcase

        slot_selected = sw.sel ? (scan_idx_q < 2'd2) : (scan_idx_q >= 2'd2);
        blank_d       = (state_q == S_ADJUST) && blink_q && slot_selected;
        an_d          = blank_d ? 4'b1111 : slot_an;
        digit_d       = slot_digit;
        running_d     = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            saved_q    <= RESET_STATE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            scan_idx_q <= 2'd0;
            blink_q    <= 1'b0;
            an_q       <= 4'b1110;
            digit_q    <= 4'd0;
            blank_q    <= 1'b0;
            running_q  <= START_RUNNING;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            scan_idx_q <= scan_idx_d;
            blink_q    <= blink_d;
            an_q       <= an_d;
            digit_q    <= digit_d;
            blank_q    <= blank_d;
            running_q  <= running_d;
        end
    end

    assign sw.min_tens = min_tens_q;
    assign sw.min_ones = min_ones_q;
    assign sw.sec_tens = sec_tens_q;
    assign sw.sec_ones = sec_ones_q;
    assign sw.an       = an_q;
    assign sw.digit    = digit_q;
    assign sw.blank    = blank_q;
    assign sw.running  = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and randomized checks of stopwatch_ctrl against a time-in-seconds model
module tb_stopwatch_ctrl;
    localparam int MIN_MAX = 59;
    localparam int ST_RUN = 0, ST_PAUSED = 1, ST_ADJ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_ctrl_if sw ();
    stopwatch_ctrl #(.MIN_MAX(MIN_MAX), .START_RUNNING(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_mm, m_ss, m_state, m_saved, m_scan;
    bit         m_blink;
    bit         g_adj, g_sel;
    logic [3:0] e_an, e_digit;
    logic       e_blank;

    function automatic int dut_mm();
        return int'(sw.min_tens) * 10 + int'(sw.min_ones);
    endfunction

    function automatic int dut_ss();
        return int'(sw.sec_tens) * 10 + int'(sw.sec_ones);
    endfunction

    function automatic int slot_value(input int slot);
        case (slot)
            0:       return m_ss % 10;
            1:       return m_ss / 10;
            2:       return m_mm % 10;
            default: return m_mm / 10;
        endcase
    endfunction

    task automatic model_reset();
        m_mm = 0; m_ss = 0; m_state = ST_RUN; m_saved = ST_RUN;
        m_scan = 0; m_blink = 1'b0;
        e_an = 4'b1110; e_digit = 4'd0; e_blank = 1'b0;
    endtask

    // One clock cycle: present inputs, advance the model by the same rules, sample 1 ns after the edge.
    task automatic step(input bit t1, input bit t2, input bit ts, input bit tbk, input bit pb);
        int total;
        sw.tick_1hz = t1; sw.tick_2hz = t2; sw.tick_scan = ts; sw.tick_blink = tbk;
        sw.pause_btn = pb; sw.adj = g_adj; sw.sel = g_sel;
        @(posedge clk);
        e_digit = 4'(slot_value(m_scan));
        e_blank = (m_state == ST_ADJ) && m_blink && (g_sel ? (m_scan < 2) : (m_scan >= 2));
        e_an    = e_blank ? 4'b1111 : ~(4'b0001 << m_scan);
        case (m_state)
            ST_RUN: begin
                if (g_adj) begin
                    m_saved = ST_RUN; m_state = ST_ADJ;
                end else begin
                    if (t1) begin
                        total = (m_mm * 60 + m_ss + 1) % ((MIN_MAX + 1) * 60);
                        m_mm = total / 60; m_ss = total % 60;
                    end
                    if (pb) m_state = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (g_adj) begin
                    m_saved = ST_PAUSED; m_state = ST_ADJ;
                end else if (pb) begin
                    m_state = ST_RUN;
                end
            end
            default: begin
                if (!g_adj) m_state = m_saved;
                else if (t2) begin
                    if (g_sel) m_ss = (m_ss + 1) % 60;
                    else       m_mm = (m_mm + 1) % (MIN_MAX + 1);
                end
            end
        endcase
        if (ts)  m_scan = (m_scan + 1) % 4;
        if (tbk) m_blink = !m_blink;
        #1;
        sw.tick_1hz = 1'b0; sw.tick_2hz = 1'b0; sw.tick_scan = 1'b0;
        sw.tick_blink = 1'b0; sw.pause_btn = 1'b0;
    endtask

    task automatic test_reset();
        g_adj = 1'b0; g_sel = 1'b0;
        sw.tick_1hz = 0; sw.tick_2hz = 0; sw.tick_scan = 0; sw.tick_blink = 0;
        sw.pause_btn = 0; sw.adj = 0; sw.sel = 0;
        rst = 1'b1;
        #13;
        n_checks++;
        if ({sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} !== 16'h0000)
            $display("FAIL reset_bcd: got %h expected 0000", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones});
        else n_pass++;
        n_checks++;
        if (sw.running !== 1'b1) $display("FAIL reset_running: got %b expected 1", sw.running);
        else n_pass++;
        n_checks++;
        if ({sw.an, sw.digit, sw.blank} !== {4'b1110, 4'd0, 1'b0})
            $display("FAIL reset_scan: got an=%b digit=%0d blank=%b expected an=1110 digit=0 blank=0", sw.an, sw.digit, sw.blank);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_count();
        for (int i = 0; i < 61; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        n_checks++;
        if (dut_mm() !== 1 || dut_ss() !== 1 || sw.running !== 1'b1)
            $display("FAIL count_61: got %0d:%0d run=%b expected 1:1 run=1", dut_mm(), dut_ss(), sw.running);
        else n_pass++;
        n_checks++;
        if (sw.an !== 4'b1110) $display("FAIL count_an: got %b expected 1110", sw.an);
        else n_pass++;
    endtask

    task automatic test_wrap();
        g_adj = 1'b1; g_sel = 1'b0;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 100 && m_mm != MIN_MAX; i++) step(0, 1, 0, 0, 0);
        g_sel = 1'b1;
        for (int i = 0; i < 100 && m_ss != 59; i++) step(0, 1, 0, 0, 0);
        n_checks++;
        if (dut_mm() !== MIN_MAX || dut_ss() !== 59)
            $display("FAIL preload: got %0d:%0d expected %0d:59", dut_mm(), dut_ss(), MIN_MAX);
        else n_pass++;
        g_adj = 1'b0;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (dut_mm() !== 0 || dut_ss() !== 0 || sw.running !== 1'b1)
            $display("FAIL full_wrap: got %0d:%0d run=%b expected 0:0 run=1", dut_mm(), dut_ss(), sw.running);
        else n_pass++;
    endtask

    task automatic test_pause();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        n_checks++;
        if (dut_mm() !== 0 || dut_ss() !== 0 || sw.running !== 1'b0)
            $display("FAIL paused_hold: got %0d:%0d run=%b expected 0:0 run=0", dut_mm(), dut_ss(), sw.running);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (dut_ss() !== 1 || sw.running !== 1'b1)
            $display("FAIL resume: got ss=%0d run=%b expected ss=1 run=1", dut_ss(), sw.running);
        else n_pass++;
    endtask

    task automatic test_adjust_paused();
        for (int i = 0; i < 57; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (dut_ss() !== 58 || sw.running !== 1'b0)
            $display("FAIL pause_at_58: got ss=%0d run=%b expected ss=58 run=0", dut_ss(), sw.running);
        else n_pass++;
        g_adj = 1'b1; g_sel = 1'b1;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        n_checks++;
        if (dut_mm() !== 0 || dut_ss() !== 1)
            $display("FAIL adj_sec_wrap: got %0d:%0d expected 0:1", dut_mm(), dut_ss());
        else n_pass++;
        g_adj = 1'b0;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (sw.running !== 1'b0 || dut_ss() !== 1)
            $display("FAIL adj_return_paused: got run=%b ss=%0d expected run=0 ss=1", sw.running, dut_ss());
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4];
        exp_an[0] = 4'b1101; exp_an[1] = 4'b1011; exp_an[2] = 4'b0111; exp_an[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (sw.an !== exp_an[i] || sw.digit !== e_digit || sw.blank !== 1'b0)
                $display("FAIL scan_%0d: got an=%b digit=%0d blank=%b expected an=%b digit=%0d blank=0",
                         i, sw.an, sw.digit, sw.blank, exp_an[i], e_digit);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_an [4];
        logic       exp_bl [4];
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1111; exp_an[3] = 4'b1111;
        exp_bl[0] = 1'b0;    exp_bl[1] = 1'b0;    exp_bl[2] = 1'b1;    exp_bl[3] = 1'b1;
        g_adj = 1'b1; g_sel = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (sw.an !== exp_an[i] || sw.blank !== exp_bl[i] || sw.digit !== e_digit)
                $display("FAIL blink_slot_%0d: got an=%b blank=%b digit=%0d expected an=%b blank=%b digit=%0d",
                         i, sw.an, sw.blank, sw.digit, exp_an[i], exp_bl[i], e_digit);
            else n_pass++;
            step(0, 0, 1, 0, 0);
        end
        g_adj = 1'b0;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        int ss0;
        step(0, 0, 0, 0, 1);
        ss0 = m_ss;
        step(1, 0, 0, 0, 1);
        n_checks++;
        if (dut_ss() !== (ss0 + 1) % 60 || sw.running !== 1'b0)
            $display("FAIL tick_and_pause: got ss=%0d run=%b expected ss=%0d run=0", dut_ss(), sw.running, (ss0 + 1) % 60);
        else n_pass++;
        g_adj = 1'b1;
        step(0, 0, 0, 0, 0);
        g_adj = 1'b0;
        step(0, 0, 0, 0, 1);
        g_adj = 1'b1;
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (dut_ss() !== m_ss || sw.running !== 1'b0)
            $display("FAIL adj_drops_tick: got ss=%0d run=%b expected ss=%0d run=0", dut_ss(), sw.running, m_ss);
        else n_pass++;
        g_adj = 1'b0;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int fails_shown = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) g_adj = !g_adj;
            if ($urandom_range(0, 29) == 0) g_sel = !g_sel;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
            n_checks++;
            if (dut_mm() !== m_mm || dut_ss() !== m_ss || sw.an !== e_an || sw.digit !== e_digit ||
                sw.blank !== e_blank || sw.running !== (m_state == ST_RUN)) begin
                if (fails_shown < 10)
                    $display("FAIL random_%0d: got %0d:%0d an=%b d=%0d bl=%b run=%b expected %0d:%0d an=%b d=%0d bl=%b run=%b",
                             i, dut_mm(), dut_ss(), sw.an, sw.digit, sw.blank, sw.running,
                             m_mm, m_ss, e_an, e_digit, e_blank, (m_state == ST_RUN));
                fails_shown++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        g_adj = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        if (m_state != ST_RUN) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} !== 16'h0000 || sw.running !== 1'b1 ||
            sw.an !== 4'b1110 || sw.digit !== 4'd0 || sw.blank !== 1'b0)
            $display("FAIL reset_async: got %0d:%0d run=%b an=%b digit=%0d blank=%b expected 0:0 run=1 an=1110 digit=0 blank=0",
                     dut_mm(), dut_ss(), sw.running, sw.an, sw.digit, sw.blank);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        g_sel = 1'b0;
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (dut_ss() !== 1 || sw.an !== 4'b1110)
            $display("FAIL after_reset_tick: got ss=%0d an=%b expected ss=1 an=1110", dut_ss(), sw.an);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adjust_paused();
        test_scan();
        test_blink();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
